// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write arbiter: bus width defaults,
// requester slot assignments and the hardwired-zero register index.
package regfile_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_NUM_REQ = 3;

  // Writeback source slots on the request vector
  localparam int unsigned REQ_ALU     = 0;
  localparam int unsigned REQ_LOAD    = 1;
  localparam int unsigned REQ_MULTDIV = 2;

  localparam int unsigned REG_ZERO    = 0;

  // Index width for a pointer over n requesters (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready write-request bundle between the writeback sources and the
// register-file write arbiter; fields are flattened per requester.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  // Writeback sources drive the request, the arbiter answers with ready
  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at NUM_REQ-1, returned as a one-hot grant plus its index.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned     pos;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      sel = IDX_W'(pos);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// sources. Optional forwarding taps enabled by REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  regfile_write_arbiter_if.slave req,
  input  logic              ctrl_stall,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [2:0]        grant_id
`ifdef REGFILE_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] fwd_addrA,
  input  logic [ADDR_W-1:0] fwd_addrB,
  output logic              fwd_hitA,
  output logic              fwd_hitB,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [ADDR_W-1:0]  win_reg;
  logic [DATA_W-1:0]  win_data;
  logic               transfer;
  logic               win_writes;

  // No grant is offered while stalled or held in reset
  assign cand = (ctrl_reset_n && !ctrl_stall) ? req.req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (cand),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign req.req_ready = grant;
  assign transfer      = win_any;

  // Winner's payload mux, driven by the one-hot grant only
  always_comb begin
    win_reg  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_reg  = req.req_reg[i*ADDR_W +: ADDR_W];
        win_data = req.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to the hardwired-zero register are accepted but never issued
  assign win_writes = transfer && (win_reg != ADDR_W'(REG_ZERO));

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (32'(win_idx) == NUM_REQ - 1) ? '0 : IDX_W'(32'(win_idx) + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      grant_id         <= '0;
    end else begin
      ctrl_writeEnable <= win_writes;
      if (win_writes) begin
        ctrl_writeReg <= win_reg;
        data_writeReg <= win_data;
        grant_id      <= 3'(win_idx);
      end
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  // Lets decode see the in-flight write before the falling-edge capture
  assign fwd_hitA = ctrl_writeEnable && (ctrl_writeReg == fwd_addrA) &&
                    (fwd_addrA != ADDR_W'(REG_ZERO));
  assign fwd_hitB = ctrl_writeEnable && (ctrl_writeReg == fwd_addrB) &&
                    (fwd_addrB != ADDR_W'(REG_ZERO));
  assign fwd_data = data_writeReg;
`endif

endmodule
